// File: rtl/sata_cmd_arbiter.sv
// Round-robin arbiter sharing the sata_stack command interface between a
// write requester and a read requester. One command in flight at a time;
// tracks sata_busy to completion, captures D2H status/error, and recovers
// hung commands by pulsing command_layer_reset after a timeout.
module sata_cmd_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned RESET_PULSE    = 16
) (
  input  logic        clk,
  input  logic        rst,
  // requesters
  input  logic        wr_req,
  input  logic [15:0] wr_sector_count,
  input  logic [47:0] wr_sector_address,
  input  logic        rd_req,
  input  logic [15:0] rd_sector_count,
  input  logic [47:0] rd_sector_address,
  output logic        wr_grant,
  output logic        rd_grant,
  output logic        wr_done,
  output logic        rd_done,
  output logic        cmd_error,
  output logic        cmd_timeout,
  output logic [7:0]  cmd_status,
  output logic [7:0]  cmd_d2h_error,
  // sata_stack side
  input  logic        linkup,
  input  logic        sata_ready,
  input  logic        sata_busy,
  input  logic [7:0]  d2h_status,
  input  logic [7:0]  d2h_error,
  output logic        write_data_en,
  output logic        read_data_en,
  output logic [15:0] sector_count,
  output logic [47:0] sector_address,
  output logic        command_layer_reset
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_COMPLETE,
    S_RESET_CL
  } state_e;

  typedef enum logic {
    OWN_WRITE,
    OWN_READ
  } owner_e;

  localparam int unsigned   PW         = (RESET_PULSE > 1) ? $clog2(RESET_PULSE) : 1;
  localparam logic [31:0]   TMO_LAST   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(RESET_PULSE - 1);

  // Every output is a flop in this set; the next-state logic computes the
  // whole set so outputs never see combinational glitches.
  typedef struct packed {
    state_e      state;
    owner_e      last_grant;
    logic        wr_grant;
    logic        rd_grant;
    logic        wr_done;
    logic        rd_done;
    logic        cmd_error;
    logic        cmd_timeout;
    logic [7:0]  cmd_status;
    logic [7:0]  cmd_d2h_error;
    logic        write_data_en;
    logic        read_data_en;
    logic [15:0] sector_count;
    logic [47:0] sector_address;
    logic        command_layer_reset;
    logic [31:0] tmo_cnt;
    logic [PW-1:0] pulse_cnt;
  } regs_t;

  regs_t r, n;
  logic  pick_wr;
  logic  finish;
  logic  fin_error;
  logic  fin_timeout;

  // State/output register bank; last_grant resets to READ so WRITE wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      r            <= '0;
      r.last_grant <= OWN_READ;
    end else begin
      r <= n;
    end
  end

  // Next-state and next-output computation for the command FSM.
  always_comb begin
    // NOTE: defaulting every field first means no path leaves a variable
    // unassigned, so no latches are inferred.
    n           = r;
    n.wr_done   = 1'b0;
    n.rd_done   = 1'b0;
    pick_wr     = 1'b0;
    finish      = 1'b0;
    fin_error   = 1'b0;
    fin_timeout = 1'b0;

    unique case (r.state)
      S_IDLE: begin
        if (linkup && sata_ready && !sata_busy && (wr_req || rd_req)) begin
          pick_wr          = wr_req && (!rd_req || r.last_grant == OWN_READ);
          n.wr_grant       = pick_wr;
          n.rd_grant       = !pick_wr;
          n.sector_count   = pick_wr ? wr_sector_count   : rd_sector_count;
          n.sector_address = pick_wr ? wr_sector_address : rd_sector_address;
          n.tmo_cnt        = '0;
          if (n.sector_count == 16'd0) begin
            // Nothing to transfer: report failure without touching the stack.
            n.state         = S_COMPLETE;
            n.wr_done       = pick_wr;
            n.rd_done       = !pick_wr;
            n.cmd_error     = 1'b1;
            n.cmd_timeout   = 1'b0;
            n.cmd_status    = 8'h00;
            n.cmd_d2h_error = 8'h00;
          end else begin
            n.state         = S_ISSUE;
            n.write_data_en = pick_wr;
            n.read_data_en  = !pick_wr;
          end
        end
      end

      S_ISSUE: begin
        n.tmo_cnt = r.tmo_cnt + 32'd1;
        if (!linkup) begin
          finish    = 1'b1;
          fin_error = 1'b1;
        end else if (sata_busy) begin
          // Busy (ours or already present) acknowledges the command.
          n.write_data_en = 1'b0;
          n.read_data_en  = 1'b0;
          n.state         = S_WAIT_DONE;
        end else if (r.tmo_cnt >= TMO_LAST) begin
          n.write_data_en       = 1'b0;
          n.read_data_en        = 1'b0;
          n.command_layer_reset = 1'b1;
          n.pulse_cnt           = '0;
          n.state               = S_RESET_CL;
        end
      end

      S_WAIT_DONE: begin
        n.tmo_cnt = r.tmo_cnt + 32'd1;
        if (!linkup) begin
          finish    = 1'b1;
          fin_error = 1'b1;
        end else if (!sata_busy) begin
          // Completion is checked before timeout so it wins a tie.
          finish    = 1'b1;
          fin_error = d2h_status[0] | (|d2h_error);
        end else if (r.tmo_cnt >= TMO_LAST) begin
          n.command_layer_reset = 1'b1;
          n.pulse_cnt           = '0;
          n.state               = S_RESET_CL;
        end
      end

      S_RESET_CL: begin
        if (r.pulse_cnt == PULSE_LAST) begin
          n.command_layer_reset = 1'b0;
          finish                = 1'b1;
          fin_error             = 1'b1;
          fin_timeout           = 1'b1;
        end else begin
          n.pulse_cnt = r.pulse_cnt + 1'b1;
        end
      end

      S_COMPLETE: begin
        n.last_grant = r.wr_grant ? OWN_WRITE : OWN_READ;
        n.wr_grant   = 1'b0;
        n.rd_grant   = 1'b0;
        n.state      = S_IDLE;
      end

      default: n.state = S_IDLE;
    endcase

    if (finish) begin
      n.state         = S_COMPLETE;
      n.write_data_en = 1'b0;
      n.read_data_en  = 1'b0;
      n.wr_done       = r.wr_grant;
      n.rd_done       = r.rd_grant;
      n.cmd_error     = fin_error;
      n.cmd_timeout   = fin_timeout;
      n.cmd_status    = d2h_status;
      n.cmd_d2h_error = d2h_error;
    end
  end

  assign wr_grant            = r.wr_grant;
  assign rd_grant            = r.rd_grant;
  assign wr_done             = r.wr_done;
  assign rd_done             = r.rd_done;
  assign cmd_error           = r.cmd_error;
  assign cmd_timeout         = r.cmd_timeout;
  assign cmd_status          = r.cmd_status;
  assign cmd_d2h_error       = r.cmd_d2h_error;
  assign write_data_en       = r.write_data_en;
  assign read_data_en        = r.read_data_en;
  assign sector_count        = r.sector_count;
  assign sector_address      = r.sector_address;
  assign command_layer_reset = r.command_layer_reset;

endmodule

// File: tb/tb_sata_cmd_arbiter.sv
// Directed testbench for sata_cmd_arbiter: inputs driven and outputs sampled
// on the falling edge, so every registered output is stable when read.
module tb_sata_cmd_arbiter;

  localparam int unsigned TMO   = 100;
  localparam int unsigned PULSE = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req, rd_req;
  logic [15:0] wr_sector_count, rd_sector_count;
  logic [47:0] wr_sector_address, rd_sector_address;
  logic        wr_grant, rd_grant, wr_done, rd_done;
  logic        cmd_error, cmd_timeout;
  logic [7:0]  cmd_status, cmd_d2h_error;
  logic        linkup, sata_ready, sata_busy;
  logic [7:0]  d2h_status, d2h_error;
  logic        write_data_en, read_data_en;
  logic [15:0] sector_count;
  logic [47:0] sector_address;
  logic        command_layer_reset;

  int tests = 0;
  int fails = 0;

  // Running observations gathered by the monitor.
  int en_cycles   = 0;
  int clr_cycles  = 0;
  int done_cnt    = 0;
  int overlap_cnt = 0;

  sata_cmd_arbiter #(.TIMEOUT_CYCLES(TMO), .RESET_PULSE(PULSE)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .wr_req              (wr_req),
    .wr_sector_count     (wr_sector_count),
    .wr_sector_address   (wr_sector_address),
    .rd_req              (rd_req),
    .rd_sector_count     (rd_sector_count),
    .rd_sector_address   (rd_sector_address),
    .wr_grant            (wr_grant),
    .rd_grant            (rd_grant),
    .wr_done             (wr_done),
    .rd_done             (rd_done),
    .cmd_error           (cmd_error),
    .cmd_timeout         (cmd_timeout),
    .cmd_status          (cmd_status),
    .cmd_d2h_error       (cmd_d2h_error),
    .linkup              (linkup),
    .sata_ready          (sata_ready),
    .sata_busy           (sata_busy),
    .d2h_status          (d2h_status),
    .d2h_error           (d2h_error),
    .write_data_en       (write_data_en),
    .read_data_en        (read_data_en),
    .sector_count        (sector_count),
    .sector_address      (sector_address),
    .command_layer_reset (command_layer_reset)
  );

  always #5 clk = ~clk;

  // Monitor: counts enable cycles, reset-pulse cycles, done pulses, overlaps.
  always @(negedge clk) begin
    if (write_data_en || read_data_en) en_cycles <= en_cycles + 1;
    if (command_layer_reset) clr_cycles <= clr_cycles + 1;
    if (wr_done || rd_done) done_cnt <= done_cnt + 1;
    if ((write_data_en && read_data_en) || (wr_grant && rd_grant))
      overlap_cnt <= overlap_cnt + 1;
  end

  // Watchdog so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_en(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (write_data_en || read_data_en) ok = 1'b1;
    end
  endtask

  task automatic wait_grant(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (wr_grant || rd_grant) ok = 1'b1;
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (wr_done || rd_done) ok = 1'b1;
    end
  endtask

  // Device model: acknowledge the enable with busy, hold it, then complete.
  task automatic device_serve(input int len, input logic [7:0] st,
                              input logic [7:0] er, output bit ok);
    wait_en(20, ok);
    if (ok) begin
      sata_busy = 1'b1;
      repeat (len) @(negedge clk);
      d2h_status = st;
      d2h_error  = er;
      sata_busy  = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_req = 1'b0; rd_req = 1'b0;
    wr_sector_count = '0; rd_sector_count = '0;
    wr_sector_address = '0; rd_sector_address = '0;
    linkup = 1'b0; sata_ready = 1'b0; sata_busy = 1'b0;
    d2h_status = '0; d2h_error = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({wr_grant, rd_grant, wr_done, rd_done, cmd_error, cmd_timeout,
         write_data_en, read_data_en, command_layer_reset} !== 9'b0) begin
      fails++; $display("FAIL reset_flags: got %b expected 0",
        {wr_grant, rd_grant, wr_done, rd_done, cmd_error, cmd_timeout,
         write_data_en, read_data_en, command_layer_reset});
    end
    tests++;
    if ({sector_count, sector_address, cmd_status, cmd_d2h_error} !== 80'h0) begin
      fails++; $display("FAIL reset_data: got %h expected 0",
        {sector_count, sector_address, cmd_status, cmd_d2h_error});
    end
    rst = 1'b0;
    // Request while link is down must wait and produce no done.
    wr_req = 1'b1; wr_sector_count = 16'h0001;
    repeat (4) @(negedge clk);
    tests++;
    if (wr_grant !== 1'b0 || done_cnt !== 0) begin
      fails++; $display("FAIL not_ready_wait: got grant=%b done_cnt=%0d expected 0/0",
        wr_grant, done_cnt);
    end
    wr_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    linkup = 1'b1; sata_ready = 1'b1;
    wr_sector_count = 16'h0008; wr_sector_address = 48'h000000001000;
    wr_req = 1'b1;
    @(negedge clk);
    tests++;
    if (wr_grant !== 1'b1 || rd_grant !== 1'b0) begin
      fails++; $display("FAIL sw_grant: got wr=%b rd=%b expected 1/0", wr_grant, rd_grant);
    end
    tests++;
    if (write_data_en !== 1'b1 || read_data_en !== 1'b0) begin
      fails++; $display("FAIL sw_enable: got wen=%b ren=%b expected 1/0",
        write_data_en, read_data_en);
    end
    tests++;
    if (sector_count !== 16'h0008 || sector_address !== 48'h000000001000) begin
      fails++; $display("FAIL sw_cmd: got %h/%h expected 0008/000000001000",
        sector_count, sector_address);
    end
    // Requester inputs change after grant; latched values must hold.
    wr_sector_count = 16'hFFFF; wr_sector_address = 48'hFFFF_FFFF_FFFF;
    @(negedge clk);
    tests++;
    if (write_data_en !== 1'b1) begin
      fails++; $display("FAIL sw_enable_hold: got %b expected 1", write_data_en);
    end
    sata_busy = 1'b1;
    @(negedge clk);
    tests++;
    if (write_data_en !== 1'b0 || wr_grant !== 1'b1) begin
      fails++; $display("FAIL sw_enable_drop: got wen=%b grant=%b expected 0/1",
        write_data_en, wr_grant);
    end
    repeat (49) @(negedge clk);
    tests++;
    if (sector_count !== 16'h0008 || sector_address !== 48'h000000001000 || wr_done !== 1'b0) begin
      fails++; $display("FAIL sw_stable: got %h/%h done=%b expected 0008/000000001000/0",
        sector_count, sector_address, wr_done);
    end
    d2h_status = 8'h50; d2h_error = 8'h00; sata_busy = 1'b0;
    @(negedge clk);
    tests++;
    if (wr_done !== 1'b1 || rd_done !== 1'b0 || cmd_error !== 1'b0 || cmd_timeout !== 1'b0) begin
      fails++; $display("FAIL sw_done: got done=%b/%b err=%b tmo=%b expected 1/0/0/0",
        wr_done, rd_done, cmd_error, cmd_timeout);
    end
    tests++;
    if (cmd_status !== 8'h50) begin
      fails++; $display("FAIL sw_status: got %h expected 50", cmd_status);
    end
    wr_req = 1'b0;
    @(negedge clk);
    tests++;
    if (wr_done !== 1'b0 || wr_grant !== 1'b0) begin
      fails++; $display("FAIL sw_release: got done=%b grant=%b expected 0/0", wr_done, wr_grant);
    end
    @(negedge clk);
    tests++;
    if (wr_grant !== 1'b0) begin
      fails++; $display("FAIL sw_no_regrant: got %b expected 0", wr_grant);
    end
  endtask

  task automatic test_contention();
    bit ok;
    rst = 1'b1;
    wr_req = 1'b1; rd_req = 1'b1;
    wr_sector_count = 16'h0010; wr_sector_address = 48'h00000000A000;
    rd_sector_count = 16'h0020; rd_sector_address = 48'h00000000B000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // First: WRITE
    wait_grant(10, ok);
    tests++;
    if (!ok || wr_grant !== 1'b1 || rd_grant !== 1'b0 || sector_count !== 16'h0010) begin
      fails++; $display("FAIL ct_first_write: got ok=%b wr=%b rd=%b cnt=%h expected 1/1/0/0010",
        ok, wr_grant, rd_grant, sector_count);
    end
    device_serve(3, 8'h50, 8'h00, ok);
    @(negedge clk);
    tests++;
    if (!ok || wr_done !== 1'b1 || rd_done !== 1'b0 || cmd_error !== 1'b0) begin
      fails++; $display("FAIL ct_write_done: got ok=%b wd=%b rdn=%b err=%b expected 1/1/0/0",
        ok, wr_done, rd_done, cmd_error);
    end
    // Second: READ (both still requesting)
    wait_grant(10, ok);
    tests++;
    if (!ok || rd_grant !== 1'b1 || wr_grant !== 1'b0 ||
        sector_count !== 16'h0020 || sector_address !== 48'h00000000B000) begin
      fails++; $display("FAIL ct_second_read: got ok=%b wr=%b rd=%b cnt=%h addr=%h expected 1/0/1/0020/00000000b000",
        ok, wr_grant, rd_grant, sector_count, sector_address);
    end
    device_serve(2, 8'h50, 8'h00, ok);
    @(negedge clk);
    tests++;
    if (!ok || rd_done !== 1'b1 || wr_done !== 1'b0) begin
      fails++; $display("FAIL ct_read_done: got ok=%b rdn=%b wd=%b expected 1/1/0",
        ok, rd_done, wr_done);
    end
    rd_req = 1'b0;
    // Third: WRITE again
    wait_grant(10, ok);
    tests++;
    if (!ok || wr_grant !== 1'b1 || rd_grant !== 1'b0) begin
      fails++; $display("FAIL ct_third_write: got ok=%b wr=%b rd=%b expected 1/1/0",
        ok, wr_grant, rd_grant);
    end
    device_serve(2, 8'h50, 8'h00, ok);
    @(negedge clk);
    tests++;
    if (!ok || wr_done !== 1'b1) begin
      fails++; $display("FAIL ct_third_done: got ok=%b wd=%b expected 1/1", ok, wr_done);
    end
    wr_req = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (overlap_cnt !== 0) begin
      fails++; $display("FAIL ct_overlap: got %0d expected 0", overlap_cnt);
    end
  endtask

  task automatic test_device_error();
    bit ok;
    rd_sector_count = 16'h0004; rd_sector_address = 48'h000000002000;
    rd_req = 1'b1;
    device_serve(2, 8'h51, 8'h04, ok);
    @(negedge clk);
    tests++;
    if (!ok || rd_done !== 1'b1 || cmd_error !== 1'b1 || cmd_timeout !== 1'b0) begin
      fails++; $display("FAIL de_flags: got ok=%b done=%b err=%b tmo=%b expected 1/1/1/0",
        ok, rd_done, cmd_error, cmd_timeout);
    end
    tests++;
    if (cmd_d2h_error !== 8'h04 || cmd_status !== 8'h51) begin
      fails++; $display("FAIL de_fields: got st=%h er=%h expected 51/04", cmd_status, cmd_d2h_error);
    end
    rd_req = 1'b0;
    @(negedge clk);
    // Clean status but nonzero error register still fails the command.
    rd_req = 1'b1;
    device_serve(2, 8'h50, 8'h10, ok);
    @(negedge clk);
    tests++;
    if (!ok || rd_done !== 1'b1 || cmd_error !== 1'b1 || cmd_d2h_error !== 8'h10) begin
      fails++; $display("FAIL de_errreg: got ok=%b done=%b err=%b er=%h expected 1/1/1/10",
        ok, rd_done, cmd_error, cmd_d2h_error);
    end
    rd_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok;
    int n_en;
    int n_clr;
    d2h_status = 8'hD0; d2h_error = 8'h00; sata_busy = 1'b0;
    wr_sector_count = 16'h0001; wr_sector_address = 48'h000000003000;
    wr_req = 1'b1;
    wait_en(10, ok);
    n_en = 0;
    while (ok && write_data_en && n_en < 300) begin
      n_en++;
      @(negedge clk);
    end
    tests++;
    if (!ok || n_en !== TMO) begin
      fails++; $display("FAIL to_enable_cycles: got ok=%b n=%0d expected 1/%0d", ok, n_en, TMO);
    end
    n_clr = 0;
    while (command_layer_reset && n_clr < 100) begin
      n_clr++;
      @(negedge clk);
    end
    tests++;
    if (n_clr !== PULSE) begin
      fails++; $display("FAIL to_reset_pulse: got %0d expected %0d", n_clr, PULSE);
    end
    tests++;
    if (wr_done !== 1'b1 || cmd_error !== 1'b1 || cmd_timeout !== 1'b1 || cmd_status !== 8'hD0) begin
      fails++; $display("FAIL to_done: got done=%b err=%b tmo=%b st=%h expected 1/1/1/d0",
        wr_done, cmd_error, cmd_timeout, cmd_status);
    end
    wr_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero_count();
    bit ok;
    int en_before;
    en_before = en_cycles;
    rd_sector_count = 16'h0000; rd_sector_address = 48'h000000004000;
    rd_req = 1'b1;
    wait_done(10, ok);
    tests++;
    if (!ok || rd_done !== 1'b1 || cmd_error !== 1'b1 || cmd_timeout !== 1'b0) begin
      fails++; $display("FAIL zc_done: got ok=%b done=%b err=%b tmo=%b expected 1/1/1/0",
        ok, rd_done, cmd_error, cmd_timeout);
    end
    tests++;
    if (cmd_status !== 8'h00 || cmd_d2h_error !== 8'h00) begin
      fails++; $display("FAIL zc_fields: got st=%h er=%h expected 00/00", cmd_status, cmd_d2h_error);
    end
    rd_req = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (en_cycles !== en_before) begin
      fails++; $display("FAIL zc_no_enable: got %0d enable cycles expected 0", en_cycles - en_before);
    end
  endtask

  task automatic test_link_loss();
    bit ok;
    int clr_before;
    clr_before = clr_cycles;
    wr_sector_count = 16'h0002; wr_sector_address = 48'h000000005000;
    wr_req = 1'b1;
    wait_en(10, ok);
    sata_busy = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (!ok || write_data_en !== 1'b0 || wr_grant !== 1'b1) begin
      fails++; $display("FAIL ll_wait: got ok=%b wen=%b grant=%b expected 1/0/1",
        ok, write_data_en, wr_grant);
    end
    linkup = 1'b0;
    @(negedge clk);
    tests++;
    if (wr_done !== 1'b1 || cmd_error !== 1'b1 || cmd_timeout !== 1'b0) begin
      fails++; $display("FAIL ll_done: got done=%b err=%b tmo=%b expected 1/1/0",
        wr_done, cmd_error, cmd_timeout);
    end
    wr_req = 1'b0; linkup = 1'b1; sata_busy = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (clr_cycles !== clr_before || command_layer_reset !== 1'b0) begin
      fails++; $display("FAIL ll_no_reset: got %0d reset cycles expected 0", clr_cycles - clr_before);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int done_before;
    wr_sector_count = 16'h0003; wr_sector_address = 48'h000000006000;
    wr_req = 1'b1;
    wait_en(10, ok);
    sata_busy = 1'b1;
    repeat (3) @(negedge clk);
    done_before = done_cnt;
    #2 rst = 1'b1;
    #1;
    tests++;
    if (!ok || {wr_grant, rd_grant, wr_done, rd_done, cmd_error, cmd_timeout,
         write_data_en, read_data_en, command_layer_reset} !== 9'b0 ||
        {sector_count, sector_address, cmd_status, cmd_d2h_error} !== 80'h0) begin
      fails++; $display("FAIL ar_immediate: got ok=%b grant=%b cnt=%h addr=%h st=%h expected 1/0/0/0/0",
        ok, wr_grant, sector_count, sector_address, cmd_status);
    end
    sata_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (wr_grant !== 1'b1 || sector_count !== 16'h0003) begin
      fails++; $display("FAIL ar_regrant: got grant=%b cnt=%h expected 1/0003", wr_grant, sector_count);
    end
    tests++;
    if (done_cnt !== done_before) begin
      fails++; $display("FAIL ar_no_done: got %0d done pulses expected 0", done_cnt - done_before);
    end
    device_serve(2, 8'h50, 8'h00, ok);
    @(negedge clk);
    tests++;
    if (!ok || wr_done !== 1'b1 || cmd_error !== 1'b0) begin
      fails++; $display("FAIL ar_complete: got ok=%b done=%b err=%b expected 1/1/0",
        ok, wr_done, cmd_error);
    end
    wr_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_device_error();
    test_timeout();
    test_zero_count();
    test_link_loss();
    test_async_reset();
    tests++;
    if (overlap_cnt !== 0) begin
      fails++; $display("FAIL final_overlap: got %0d expected 0", overlap_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
